// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and the requester-id type for the register-file writeback scheduler.
package regfile_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned NUM_REGS       = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer only moves on a contested grant.
module rr_arbiter2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] grant_c
);

  req_id_e last_q;
  req_id_e last_d;

  always_comb begin
    grant_c = 2'b00;
    last_d  = last_q;
    case (req_i)
      2'b01: grant_c = 2'b01;
      2'b10: grant_c = 2'b10;
      2'b11: begin
        if (last_q == REQ_B) begin
          grant_c = 2'b01;
          last_d  = REQ_A;
        end else begin
          grant_c = 2'b10;
          last_d  = REQ_B;
        end
      end
      default: grant_c = 2'b00;
    endcase
  end

  // Reset favours A in the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Destination-register scoreboard plus two-port writeback arbitration into a
// single registered register-file write port.
module regfile_wb_scheduler
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  issueValid,
  input  logic [ADDR_WIDTH-1:0] issueIndex,
  output logic                  issueReady,
  input  logic [ADDR_WIDTH-1:0] checkIndex1,
  input  logic [ADDR_WIDTH-1:0] checkIndex2,
  output logic                  hazard,
  input  logic                  wbValidA,
  input  logic                  wbValidB,
  input  logic [ADDR_WIDTH-1:0] wbIndexA,
  input  logic [ADDR_WIDTH-1:0] wbIndexB,
  input  logic [DATA_WIDTH-1:0] wbDataA,
  input  logic [DATA_WIDTH-1:0] wbDataB,
  output logic                  wbReadyA,
  output logic                  wbReadyB,
  output logic [ADDR_WIDTH-1:0] writeIndex,
  output logic [DATA_WIDTH-1:0] writeContent,
  output logic                  writeFlag
);

  localparam int unsigned NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:1]      busy_q;
  logic [NREGS-1:1]      busy_d;
  logic [NREGS-1:0]      busy_full;
  logic                  issue_acc;
  logic [1:0]            req;
  logic [1:0]            grant;
  logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_flag_q, wr_flag_d;

  // Index 0 is hard-wired not-busy so it is always issuable and never hazards.
  assign busy_full  = {busy_q, 1'b0};
  assign issue_acc  = resetN & issueValid & ~busy_full[issueIndex];
  assign issueReady = issue_acc;
  assign hazard     = resetN & (busy_full[checkIndex1] | busy_full[checkIndex2]);

  assign req      = {wbValidB & resetN, wbValidA & resetN};
  assign wbReadyA = grant[0];
  assign wbReadyB = grant[1];

  rr_arbiter2 u_arb (
    .clk    (clock),
    .rst_n  (resetN),
    .req_i  (req),
    .grant_c(grant)
  );

  // Clear on the edge the register file captures the write; set on accepted issue.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (wr_flag_q && wr_idx_q == ADDR_WIDTH'(i)) busy_d[i] = 1'b0;
      if (issue_acc && issueIndex == ADDR_WIDTH'(i)) busy_d[i] = 1'b1;
    end
  end

  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    wr_flag_d = 1'b0;
    if (grant[0]) begin
      wr_idx_d  = wbIndexA;
      wr_data_d = wbDataA;
      wr_flag_d = (wbIndexA != '0);
    end else if (grant[1]) begin
      wr_idx_d  = wbIndexB;
      wr_data_d = wbDataB;
      wr_flag_d = (wbIndexB != '0);
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      busy_q    <= '0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      wr_flag_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      wr_flag_q <= wr_flag_d;
    end
  end

  assign writeIndex   = wr_idx_q;
  assign writeContent = wr_data_q;
  assign writeFlag    = wr_flag_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: combinational handshakes checked inline, register-file writes
// checked by a monitor against a queue of expected writes.
module tb_regfile_wb_scheduler;
  import regfile_ctrl_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clock;
  logic          resetN;
  logic          issueValid;
  logic [AW-1:0] issueIndex;
  logic          issueReady;
  logic [AW-1:0] checkIndex1;
  logic [AW-1:0] checkIndex2;
  logic          hazard;
  logic          wbValidA, wbValidB;
  logic [AW-1:0] wbIndexA, wbIndexB;
  logic [DW-1:0] wbDataA, wbDataB;
  logic          wbReadyA, wbReadyB;
  logic [AW-1:0] writeIndex;
  logic [DW-1:0] writeContent;
  logic          writeFlag;

  int n_checks = 0;
  int n_fails  = 0;

  logic [AW-1:0] exp_idx[$];
  logic [DW-1:0] exp_data[$];

  regfile_wb_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .issueValid  (issueValid),
    .issueIndex  (issueIndex),
    .issueReady  (issueReady),
    .checkIndex1 (checkIndex1),
    .checkIndex2 (checkIndex2),
    .hazard      (hazard),
    .wbValidA    (wbValidA),
    .wbValidB    (wbValidB),
    .wbIndexA    (wbIndexA),
    .wbIndexB    (wbIndexB),
    .wbDataA     (wbDataA),
    .wbDataB     (wbDataB),
    .wbReadyA    (wbReadyA),
    .wbReadyB    (wbReadyB),
    .writeIndex  (writeIndex),
    .writeContent(writeContent),
    .writeFlag   (writeFlag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] idx, input logic [DW-1:0] data);
    exp_idx.push_back(idx);
    exp_data.push_back(data);
  endtask

  // Monitor: every register-file write must match the next expected one.
  always @(negedge clock) begin
    if (resetN && writeFlag) begin
      if (exp_idx.size() == 0) begin
        check("unexpected_write", 32'(writeIndex), 32'hFFFF_FFFF);
      end else begin
        check("write_index", 32'(writeIndex), 32'(exp_idx.pop_front()));
        check("write_content", writeContent, exp_data.pop_front());
      end
    end
  end

  initial begin
    logic [AW-1:0] top_idx;
    top_idx = AW'(NUM_REGS - 1);

    resetN = 1'b0;
    issueValid = 1'b1; issueIndex = 5'd5;
    checkIndex1 = 5'd0; checkIndex2 = 5'd0;
    wbValidA = 1'b1; wbIndexA = 5'd1; wbDataA = 32'h1;
    wbValidB = 1'b1; wbIndexB = 5'd2; wbDataB = 32'h2;
    #3;
    check("rst_issueReady", 32'(issueReady), 32'd0);
    check("rst_wbReadyA", 32'(wbReadyA), 32'd0);
    check("rst_wbReadyB", 32'(wbReadyB), 32'd0);
    check("rst_writeFlag", 32'(writeFlag), 32'd0);
    check("rst_writeIndex", 32'(writeIndex), 32'd0);
    check("rst_writeContent", writeContent, 32'd0);
    check("rst_hazard", 32'(hazard), 32'd0);
    issueValid = 1'b0; wbValidA = 1'b0; wbValidB = 1'b0;
    step();
    resetN = 1'b1;
    step();

    // Reserve 5, see hazard, reissue refused.
    issueValid = 1'b1; issueIndex = 5'd5;
    #1 check("issue5_ready", 32'(issueReady), 32'd1);
    step();
    issueValid = 1'b0; checkIndex1 = 5'd5;
    #1 check("hazard5", 32'(hazard), 32'd1);
    issueValid = 1'b1;
    #1 check("reissue5_ready", 32'(issueReady), 32'd0);
    issueValid = 1'b0;

    // Writeback to 5; hazard holds through the write cycle.
    wbValidA = 1'b1; wbIndexA = 5'd5; wbDataA = 32'hDEADBEEF;
    #1 check("wb5_readyA", 32'(wbReadyA), 32'd1);
    push_wr(5'd5, 32'hDEADBEEF);
    step();
    wbValidA = 1'b0;
    #1 check("wb5_flag", 32'(writeFlag), 32'd1);
    check("wb5_hazard_hold", 32'(hazard), 32'd1);
    step();
    check("wb5_hazard_clear", 32'(hazard), 32'd0);
    checkIndex1 = 5'd0;

    // Contested writebacks alternate A,B,A,B.
    wbValidA = 1'b1; wbIndexA = 5'd3; wbDataA = 32'h0000_0333;
    wbValidB = 1'b1; wbIndexB = 5'd4; wbDataB = 32'h0000_0444;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rr_readyA", 32'(wbReadyA), 32'((c % 2) == 0));
      check("rr_readyB", 32'(wbReadyB), 32'((c % 2) == 1));
      if ((c % 2) == 0) push_wr(5'd3, 32'h0000_0333);
      else              push_wr(5'd4, 32'h0000_0444);
      step();
    end
    wbValidB = 1'b0;

    // Lone A grant must not move the pointer: next contest still goes to A.
    wbIndexA = 5'd8; wbDataA = 32'h0000_0888;
    #1 check("lone_readyA", 32'(wbReadyA), 32'd1);
    push_wr(5'd8, 32'h0000_0888);
    step();
    wbValidB = 1'b1; wbIndexA = 5'd10; wbDataA = 32'h0000_0AAA;
    wbIndexB = 5'd11; wbDataB = 32'h0000_0BBB;
    #1 check("post_lone_readyA", 32'(wbReadyA), 32'd1);
    check("post_lone_readyB", 32'(wbReadyB), 32'd0);
    push_wr(5'd10, 32'h0000_0AAA);
    step();
    wbValidA = 1'b0; wbValidB = 1'b0;

    // Writeback to index 0: handshake only.
    wbValidB = 1'b1; wbIndexB = 5'd0; wbDataB = 32'h0000_1234;
    #1 check("wb0_readyB", 32'(wbReadyB), 32'd1);
    step();
    wbValidB = 1'b0;
    #1 check("wb0_flag", 32'(writeFlag), 32'd0);

    // Clear 7 and set 9 on the same edge.
    issueValid = 1'b1; issueIndex = 5'd7;
    #1 check("issue7_ready", 32'(issueReady), 32'd1);
    step();
    issueValid = 1'b0;
    wbValidA = 1'b1; wbIndexA = 5'd7; wbDataA = 32'h0000_0777;
    #1 check("wb7_readyA", 32'(wbReadyA), 32'd1);
    push_wr(5'd7, 32'h0000_0777);
    step();
    wbValidA = 1'b0;
    issueValid = 1'b1; issueIndex = 5'd9;
    #1 check("issue9_ready", 32'(issueReady), 32'd1);
    step();
    issueValid = 1'b0;
    checkIndex1 = 5'd7; checkIndex2 = 5'd0;
    #1 check("busy7_cleared", 32'(hazard), 32'd0);
    checkIndex1 = 5'd0; checkIndex2 = 5'd9;
    #1 check("busy9_set", 32'(hazard), 32'd1);

    // Highest index is tracked like any other.
    issueValid = 1'b1; issueIndex = top_idx;
    #1 check("issue_top_ready", 32'(issueReady), 32'd1);
    step();
    issueValid = 1'b0; checkIndex1 = top_idx; checkIndex2 = 5'd0;
    #1 check("hazard_top", 32'(hazard), 32'd1);

    // Async reset while busy[2] and a write is on the port.
    issueValid = 1'b1; issueIndex = 5'd2;
    step();
    issueValid = 1'b0;
    wbValidA = 1'b1; wbIndexA = 5'd2; wbDataA = 32'h0000_00AA;
    push_wr(5'd2, 32'h0000_00AA);
    step();
    wbValidA = 1'b0; checkIndex1 = 5'd2;
    @(negedge clock);
    #2;
    check("pre_rst_flag", 32'(writeFlag), 32'd1);
    resetN = 1'b0;
    issueValid = 1'b1; issueIndex = 5'd3;
    wbValidA = 1'b1; wbIndexA = 5'd6;
    #1;
    check("midrst_flag", 32'(writeFlag), 32'd0);
    check("midrst_index", 32'(writeIndex), 32'd0);
    check("midrst_content", writeContent, 32'd0);
    check("midrst_hazard", 32'(hazard), 32'd0);
    check("midrst_issueReady", 32'(issueReady), 32'd0);
    check("midrst_wbReadyA", 32'(wbReadyA), 32'd0);
    issueValid = 1'b0; wbValidA = 1'b0;
    #3 resetN = 1'b1;
    step();
    checkIndex1 = 5'd2; checkIndex2 = 5'd9;
    #1 check("post_rst_hazard", 32'(hazard), 32'd0);
    issueValid = 1'b1; issueIndex = 5'd2;
    #1 check("post_rst_issue2", 32'(issueReady), 32'd1);
    step();
    issueValid = 1'b0;
    step();

    check("pending_writes_left", 32'(exp_idx.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 32, register data width.
REQ-002 Parameter ADDR_WIDTH, 5, register index width; index 0 is hard-zero and never written.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 resetN  input  1  reset, asynchronous, active-low.
REQ-005 issueValid  input  1  decode requests to reserve destination register.
REQ-006 issueIndex  input  ADDR_WIDTH  destination register to reserve.
REQ-007 issueReady  output  1  reservation accepted this cycle.
REQ-008 checkIndex1, checkIndex2  input  ADDR_WIDTH  source registers to hazard-check.
REQ-009 hazard  output  1  either source register has a pending write.
REQ-010 wbValidA, wbValidB  input  1  writeback request from requester A (ALU) / B (memory).
REQ-011 wbIndexA, wbIndexB  input  ADDR_WIDTH  writeback destination.
REQ-012 wbDataA, wbDataB  input  DATA_WIDTH  writeback data.
REQ-013 wbReadyA, wbReadyB  output  1  writeback granted this cycle.
REQ-014 writeIndex  output  ADDR_WIDTH  register file write index, registered.
REQ-015 writeContent  output  DATA_WIDTH  register file write data, registered.
REQ-016 writeFlag  output  1  register file write enable, registered.

Function
REQ-017 Scoreboard SHALL be a 31-bit busy vector for indices 1..31; index 0 always reads not-busy.
REQ-018 issueReady SHALL be combinational: issueValid high and busy[issueIndex] low; issueIndex 0 SHALL always be ready and set nothing.
REQ-019 Accepted issue SHALL set busy[issueIndex] on the same rising edge.
REQ-020 hazard SHALL be combinational: busy[checkIndex1] OR busy[checkIndex2].
REQ-021 Arbitration SHALL grant at most one requester per cycle; a lone valid requester SHALL always be granted.
REQ-022 With both valid, grant SHALL go to the requester not granted last; last-granted pointer updates only on a contested grant.
REQ-023 wbReadyA/wbReadyB SHALL be combinational and equal the grant; handshake completes when valid and ready are both high.
REQ-024 Granted request SHALL be registered to writeIndex/writeContent with writeFlag high one cycle later (latency 1); writeFlag low in cycles with no grant.
REQ-025 Granted request with index 0 SHALL be handshaken but SHALL NOT raise writeFlag.
REQ-026 busy[writeIndex] SHALL clear on the rising edge where writeFlag is high (same edge the register file captures), so hazard stays high through the cycle after grant.
REQ-027 Writeback to a non-busy index SHALL still be written; busy unchanged.
REQ-028 Simultaneous clear and issue of the same index SHALL NOT occur, because issueReady is low while busy; clear of index X and set of index Y≠X in one edge SHALL both take effect.
REQ-029 Requesters SHALL hold wbIndex/wbData stable while valid and not ready; scheduler takes no action on changes while not granted.

Reset
REQ-030 resetN low SHALL immediately clear busy vector, writeFlag, writeIndex, writeContent, and set last-granted pointer to B (A wins first contest).
REQ-031 With resetN low, issueReady, wbReadyA, wbReadyB and hazard SHALL be low; requests in flight SHALL be dropped.
REQ-032 Reset deassertion mid-operation SHALL resume with empty scoreboard; first edge after deassertion accepts new requests normally.

Structure
REQ-033 Package regfile_ctrl_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, register count (32), and the requester-id enum (REQ_A, REQ_B).
REQ-034 Two-way round-robin SHALL be a sub-module rr_arbiter2 (req[1:0] in, grant[1:0] out, internal last-grant flop); scoreboard and write register stay in the top.

Verification
REQ-035 Reset, issue index 5 -> issueReady=1; next cycle checkIndex1=5 -> hazard=1; reissue 5 -> issueReady=0.
REQ-036 busy[5]; wbValidA index 5 data 0xDEADBEEF -> wbReadyA=1 same cycle; next cycle writeFlag=1, writeIndex=5, writeContent=0xDEADBEEF, hazard still 1; following cycle hazard=0.
REQ-037 Both valid for 4 cycles, indices 3 (A) and 4 (B) -> grants A,B,A,B; writeIndex sequence 3,4,3,4 one cycle delayed.
REQ-038 wbValidB index 0 data 0x1234 -> wbReadyB=1, writeFlag stays 0.
REQ-039 Same edge: writeFlag clears index 7, issue index 9 accepted -> busy[7]=0, busy[9]=1.
REQ-040 resetN asserted mid-cycle with busy[2] and writeFlag high -> outputs 0 immediately without clock; after release checkIndex1=2 -> hazard=0.
